// File: rtl/sram_adapter_pkg.sv
// Shared widths, request payload and sizing helper for the SRAM RW request adapter.
package sram_adapter_pkg;

    localparam int unsigned SRAM_ADDR_W  = 9;
    localparam int unsigned SRAM_DATA_W  = 128;
    localparam int unsigned SRAM_MASK_W  = 4;
    localparam int unsigned SRAM_Q_DEPTH = 2;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_MASK_W-1:0] wmask;
    } req_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response FIFO; the output is always the registered head entry, so a push
// into an empty FIFO becomes visible one cycle later.
module sram_resp_fifo
    import sram_adapter_pkg::*;
#(
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned DEPTH  = SRAM_Q_DEPTH
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_push,
    input  logic [DATA_W-1:0]               i_push_data,
    input  logic                            i_pop,
    output logic                            o_valid,
    output logic [DATA_W-1:0]               o_data,
    output logic [clog2(DEPTH + 1)-1:0]     o_count
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;

    assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));
            assert (!(i_pop && (r_count == '0)));
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= w_wr_nxt;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sram_rw_req_adapter.sv
// Valid/ready front end for a single-port RW SRAM macro: issues requests straight onto
// the macro port and returns read data in order through a credit-guarded FIFO.
module sram_rw_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int unsigned ADDR_W  = SRAM_ADDR_W,
    parameter int unsigned DATA_W  = SRAM_DATA_W,
    parameter int unsigned MASK_W  = SRAM_MASK_W,
    parameter int unsigned Q_DEPTH = SRAM_Q_DEPTH
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int unsigned CNT_W = clog2(Q_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    req_t             w_req;
    logic             w_accept;
    logic             w_resp_fire;
    logic [CNT_W-1:0] w_count;
    logic [CRD_W-1:0] w_credit_used;
    logic             r_ready_en;
    logic             r_inflight;

    // Holds req_ready low until the first clock edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // Every accepted read owns a FIFO slot; a pop in this cycle frees one immediately.
    assign w_resp_fire   = resp_valid && resp_ready;
    assign w_credit_used = CRD_W'(w_count) + CRD_W'(r_inflight) - CRD_W'(w_resp_fire);
    assign req_ready     = r_ready_en && (w_credit_used < CRD_W'(Q_DEPTH));
    assign w_accept      = req_valid && req_ready;

    always_comb begin
        w_req = '0;
        if (w_accept) begin
            w_req.write = req_write;
            w_req.addr  = SRAM_ADDR_W'(req_addr);
            w_req.wdata = SRAM_DATA_W'(req_wdata);
            w_req.wmask = SRAM_MASK_W'(req_wmask);
        end
    end

    assign sram_en    = w_accept;
    assign sram_wmode = w_req.write;
    assign sram_addr  = ADDR_W'(w_req.addr);
    assign sram_wmask = MASK_W'(w_req.wmask);
    assign sram_wdata = DATA_W'(w_req.wdata);

    // Macro read data is valid exactly one cycle after a read enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept && !req_write;
        end
    end

    sram_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (Q_DEPTH)
    ) u_resp_fifo (
        .clk         (clock),
        .rst_n       (reset_n),
        .i_push      (r_inflight),
        .i_push_data (sram_rdata),
        .i_pop       (w_resp_fire),
        .o_valid     (resp_valid),
        .o_data      (resp_rdata),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_sram_rw_req_adapter.sv
// Directed and randomised bench for sram_rw_req_adapter with a behavioural 1-cycle RW SRAM.
module tb_sram_rw_req_adapter;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned Q_DEPTH = 2;
    localparam int unsigned GRAN    = DATA_W / MASK_W;
    localparam int unsigned ROWS    = 512;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    logic [DATA_W-1:0] sram_mem [ROWS];
    logic [DATA_W-1:0] shadow   [ROWS];
    logic [DATA_W-1:0] exp_q [$];

    int n_checks;
    int n_fail;
    int m_count;
    bit m_inflight;
    bit m_ready_en;
    int cyc;
    int fire_n;
    int fire_first;
    int fire_last;

    sram_rw_req_adapter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MASK_W  (MASK_W),
        .Q_DEPTH (Q_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural macro: masked write, registered read.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int g = 0; g < int'(MASK_W); g++) begin
                    if (sram_wmask[g]) begin
                        sram_mem[sram_addr][g*GRAN +: GRAN] <= sram_wdata[g*GRAN +: GRAN];
                    end
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                                input logic [DATA_W-1:0] new_d,
                                                input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int g = 0; g < int'(MASK_W); g++) begin
            if (m[g]) r[g*GRAN +: GRAN] = new_d[g*GRAN +: GRAN];
        end
        return r;
    endfunction

    task automatic drive(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic model_reset();
        m_count    = 0;
        m_inflight = 1'b0;
        m_ready_en = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: check at the falling edge, advance the model, return 1 ns after the rising edge.
    task automatic step(output bit acc);
        bit m_fire;
        bit exp_rdy;
        @(negedge clock);
        acc     = req_valid && req_ready;
        m_fire  = (m_count > 0) && resp_ready;
        exp_rdy = m_ready_en && reset_n &&
                  ((m_count + int'(m_inflight) - int'(m_fire)) < int'(Q_DEPTH));
        chk("req_ready", DATA_W'(req_ready), DATA_W'(exp_rdy));
        chk("resp_valid", DATA_W'(resp_valid), DATA_W'(m_count > 0));
        if (m_fire && exp_q.size() > 0) begin
            chk("resp_rdata", resp_rdata, exp_q.pop_front());
        end
        if (resp_valid && resp_ready) begin
            if (fire_n == 0) fire_first = cyc;
            fire_last = cyc;
            fire_n++;
        end
        if (acc) begin
            chk("sram_en", DATA_W'(sram_en), DATA_W'(1));
            chk("sram_wmode", DATA_W'(sram_wmode), DATA_W'(req_write));
            chk("sram_addr", DATA_W'(sram_addr), DATA_W'(req_addr));
            if (req_write) begin
                chk("sram_wmask", DATA_W'(sram_wmask), DATA_W'(req_wmask));
                chk("sram_wdata", sram_wdata, req_wdata);
                shadow[req_addr] = merge(shadow[req_addr], req_wdata, req_wmask);
            end else begin
                exp_q.push_back(shadow[req_addr]);
            end
        end else begin
            chk("sram_idle", DATA_W'(sram_en), DATA_W'(0));
        end
        m_count    = m_count + int'(m_inflight) - int'(m_fire);
        m_inflight = acc && !req_write;
        m_ready_en = reset_n;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit acc;
        bit v;
        bit w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        fire_n   = 0;
        fire_first = 0;
        fire_last  = 0;
        for (int i = 0; i < int'(ROWS); i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
        sram_rdata = '0;
        reset_n    = 1'b0;
        resp_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        model_reset();

        // Power-on reset values
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", DATA_W'(req_ready), DATA_W'(0));
        chk("rst_resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        chk("rst_resp_rdata", resp_rdata, DATA_W'(0));
        chk("rst_sram_en", DATA_W'(sram_en), DATA_W'(0));
        reset_n = 1'b1;
        step(acc);
        step(acc);
        chk("ready_after_rst", DATA_W'(req_ready), DATA_W'(1));

        // Full write then read-after-write, latency 2
        resp_ready = 1'b1;
        drive(1'b1, 1'b1, 9'h005, {16{8'hA5}}, 4'b1111);
        step(acc);
        chk("wr_acc", DATA_W'(acc), DATA_W'(1));
        drive(1'b1, 1'b0, 9'h005, '0, '0);
        step(acc);
        chk("rd_acc", DATA_W'(acc), DATA_W'(1));
        drive(1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("rd_lat1_valid", DATA_W'(resp_valid), DATA_W'(0));
        step(acc);
        chk("rd_lat2_valid", DATA_W'(resp_valid), DATA_W'(1));
        chk("rd_lat2_data", resp_rdata, {16{8'hA5}});
        step(acc);

        // Zero-mask write still pulses the macro but leaves the row alone
        drive(1'b1, 1'b1, 9'h005, '0, 4'b0000);
        step(acc);
        drive(1'b1, 1'b0, 9'h005, '0, '0);
        step(acc);
        drive(1'b0, 1'b0, '0, '0, '0);
        step(acc);
        chk("mask0_data", resp_rdata, {16{8'hA5}});
        step(acc);

        // Partial mask 4'b0100 touches bits [95:64] only
        drive(1'b1, 1'b1, 9'h010, '0, 4'b1111);
        step(acc);
        drive(1'b1, 1'b1, 9'h010, {DATA_W{1'b1}}, 4'b0100);
        step(acc);
        drive(1'b1, 1'b0, 9'h010, '0, '0);
        step(acc);
        drive(1'b0, 1'b0, '0, '0, '0);
        step(acc);
        chk("pmask_data", resp_rdata, {32'h0, 32'hFFFF_FFFF, 64'h0});
        step(acc);

        // Back-to-back reads 0x000..0x00F
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, ADDR_W'(i), {4{32'hBEEF_0000 | 32'(i)}}, 4'b1111);
            step(acc);
        end
        fire_n = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, ADDR_W'(i), '0, '0);
            #1;
            chk("b2b_ready", DATA_W'(req_ready), DATA_W'(1));
            if (i == 2) chk("b2b_first_data", resp_rdata, {4{32'hBEEF_0000}});
            step(acc);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        repeat (4) step(acc);
        chk("b2b_count", DATA_W'(fire_n), DATA_W'(16));
        chk("b2b_consec", DATA_W'(fire_last - fire_first), DATA_W'(15));

        // Credit limit with a stalled consumer
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 9'h001, '0, '0);
        #1;
        chk("cred_rdy0", DATA_W'(req_ready), DATA_W'(1));
        step(acc);
        drive(1'b1, 1'b0, 9'h002, '0, '0);
        #1;
        chk("cred_rdy1", DATA_W'(req_ready), DATA_W'(1));
        step(acc);
        drive(1'b1, 1'b0, 9'h003, '0, '0);
        #1;
        chk("cred_rdy2", DATA_W'(req_ready), DATA_W'(0));
        step(acc);
        chk("cred_noacc", DATA_W'(acc), DATA_W'(0));
        chk("cred_full_valid", DATA_W'(resp_valid), DATA_W'(1));
        chk("cred_rdy3", DATA_W'(req_ready), DATA_W'(0));
        resp_ready = 1'b1;
        #1;
        chk("cred_rdy_pop", DATA_W'(req_ready), DATA_W'(1));
        chk("cred_head", resp_rdata, {4{32'hBEEF_0001}});
        step(acc);
        chk("cred_acc_pop", DATA_W'(acc), DATA_W'(1));
        drive(1'b0, 1'b0, '0, '0, '0);
        repeat (4) step(acc);

        // Randomised mixed traffic with consumer stalls
        acc = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if (acc || !req_valid) begin
                v = ($urandom_range(0, 3) != 0);
                w = 1'($urandom_range(0, 1));
                a = ADDR_W'($urandom_range(0, 31));
                d = {$urandom, $urandom, $urandom, $urandom};
                m = MASK_W'($urandom_range(0, 15));
                drive(v, w, a, d, m);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        resp_ready = 1'b1;
        repeat (4) step(acc);
        chk("rand_drain", DATA_W'(exp_q.size()), DATA_W'(0));

        // Asynchronous reset with one entry queued and one read in flight
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 9'h007, '0, '0);
        step(acc);
        drive(1'b1, 1'b0, 9'h008, '0, '0);
        step(acc);
        chk("rstmid_pre_valid", DATA_W'(resp_valid), DATA_W'(1));
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 9'h009, '0, '0);
        #1;
        chk("rstmid_valid", DATA_W'(resp_valid), DATA_W'(0));
        chk("rstmid_ready", DATA_W'(req_ready), DATA_W'(0));
        chk("rstmid_sram_en", DATA_W'(sram_en), DATA_W'(0));
        model_reset();
        step(acc);
        reset_n = 1'b1;
        resp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        repeat (4) step(acc);
        chk("rstmid_nostale", DATA_W'(resp_valid), DATA_W'(0));
        chk("rstmid_ready_back", DATA_W'(req_ready), DATA_W'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
